// File: rtl/school_mips_cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : school_mips_cpu_pkg
// Purpose  : Shared definitions for the single-cycle MIPS-subset core:
//            opcode and funct field constants, ALU operation encoding and a
//            sign-extension helper. Also used by the bench disassembler.
// Revision : 1.0  initial release
// ============================================================================
package school_mips_cpu_pkg;

  // Primary opcodes, instr[31:26]
  localparam logic [5:0] C_SPEC  = 6'b000000;
  localparam logic [5:0] C_SPEC2 = 6'b011100;
  localparam logic [5:0] C_ADDIU = 6'b001001;
  localparam logic [5:0] C_LUI   = 6'b001111;
  localparam logic [5:0] C_ANDI  = 6'b001100;
  localparam logic [5:0] C_BEQ   = 6'b000100;
  localparam logic [5:0] C_BNE   = 6'b000101;
  localparam logic [5:0] C_BGEZ  = 6'b000001;

  // Function codes, instr[5:0]. F_MUL is only meaningful under C_SPEC2.
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_SLTU  = 6'b101011;
  localparam logic [5:0] F_SUBU  = 6'b100011;
  localparam logic [5:0] F_SRLV  = 6'b000110;
  localparam logic [5:0] F_MUL   = 6'b000010;
  // Wildcard for casez decoding of opcodes that do not use the funct field
  localparam logic [5:0] F_ANY   = 6'b??????;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_OR   = 4'd2,
    ALU_AND  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_SRL  = 4'd5,
    ALU_SRLV = 4'd6,
    ALU_MUL  = 4'd7,
    ALU_LUI  = 4'd8
  } aluOp_t;

  function automatic logic [31:0] signExt16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage
`default_nettype wire

// File: rtl/school_mips_cpu_if.sv
`default_nettype none
// ============================================================================
// Module   : school_mips_cpu_if
// Purpose  : Bus bundle between the core and its environment.
//   imAddr  : instruction word address (core -> ROM)
//   imData  : instruction word (ROM -> core, combinational)
//   regAddr : debug select, 0 = PC, 1..31 = GPR
//   regData : debug read data (core -> environment, combinational)
// Revision : 1.0  initial release
// ============================================================================
interface school_mips_cpu_if;
  logic [31:0] imAddr;
  logic [31:0] imData;
  logic [4:0]  regAddr;
  logic [31:0] regData;

  // master: the CPU core
  modport master (output imAddr, input imData, input regAddr, output regData);
  // slave: instruction memory plus debug host
  modport slave  (input imAddr, output imData, output regAddr, input regData);
endinterface
`default_nettype wire

// File: rtl/school_mips_cpu_regfile.sv
`default_nettype none
// ============================================================================
// Module   : sm_register_file
// Purpose  : 32x32 GPR file, two asynchronous operand read ports, one
//            asynchronous debug read port and one write port written on the
//            rising edge. $0 always reads as zero; writes to $0 are dropped.
//   clk                  : clock
//   rdAddr0/rdData0      : operand port A (rs)
//   rdAddr1/rdData1      : operand port B (rt)
//   rdAddrDbg/rdDataDbg  : debug read port
//   wrAddr/wrData/wrEn   : write port
// Revision : 1.0  initial release
// ============================================================================
module sm_register_file (
  input  logic        clk,
  input  logic [4:0]  rdAddr0,
  input  logic [4:0]  rdAddr1,
  input  logic [4:0]  rdAddrDbg,
  output logic [31:0] rdData0,
  output logic [31:0] rdData1,
  output logic [31:0] rdDataDbg,
  input  logic [4:0]  wrAddr,
  input  logic [31:0] wrData,
  input  logic        wrEn
);

  // Storage is not reset; its name is relied on for hierarchical preload.
  logic [31:0] rf [32];

  assign rdData0   = (rdAddr0   == 5'd0) ? 32'd0 : rf[rdAddr0];
  assign rdData1   = (rdAddr1   == 5'd0) ? 32'd0 : rf[rdAddr1];
  assign rdDataDbg = (rdAddrDbg == 5'd0) ? 32'd0 : rf[rdAddrDbg];

  always_ff @(posedge clk) begin
    if (wrEn && (wrAddr != 5'd0)) begin
      rf[wrAddr] <= wrData;
    end
  end

endmodule
`default_nettype wire

// File: rtl/school_mips_cpu.sv
`default_nettype none
// ============================================================================
// Module   : school_mips_cpu
// Purpose  : Single-cycle MIPS-subset core. One instruction per clock, no
//            pipeline, no branch delay slot. Fetches from a combinational
//            word-addressed ROM and exposes a debug read port.
//   clk  : clock, all state updates on the rising edge
//   rst  : synchronous active-high reset (PC <= RESET_PC, no GPR writes)
//   bus  : master side of school_mips_cpu_if (imAddr/imData, regAddr/regData)
// Revision : 1.0  initial release
// ============================================================================
module school_mips_cpu
  import school_mips_cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic              clk,
  input  logic              rst,
  school_mips_cpu_if.master bus
);

  logic [31:0] r_pc;
  logic [31:0] instr;

  logic [5:0]  w_op;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [4:0]  w_sa;
  logic [5:0]  w_funct;
  logic [15:0] w_imm;

  logic [31:0] w_rsData;
  logic [31:0] w_rtData;
  logic [31:0] w_dbgData;

  // decoder outputs
  logic        w_regWrite;
  logic        w_dstRt;
  logic        w_useImm;
  logic        w_zeroExt;
  logic        w_isBeq;
  logic        w_isBne;
  logic        w_isBgez;
  aluOp_t      w_aluOp;

  logic [31:0] w_srcB;
  logic [31:0] w_aluResult;
  logic [4:0]  w_wrAddr;
  logic        w_wrEn;
  logic        w_taken;
  logic [31:0] w_pcNext;

  // ---------------------------------------------------------------- fetch
  assign bus.imAddr = r_pc;
  assign instr      = bus.imData;

  assign w_op    = instr[31:26];
  assign w_rs    = instr[25:21];
  assign w_rt    = instr[20:16];
  assign w_rd    = instr[15:11];
  assign w_sa    = instr[10:6];
  assign w_funct = instr[5:0];
  assign w_imm   = instr[15:0];

  // --------------------------------------------------------------- decode
  // Anything not matched below (including the all-zero NOP) falls through
  // to the defaults: no register write, sequential PC.
  always_comb begin
    w_regWrite = 1'b0;
    w_dstRt    = 1'b0;
    w_useImm   = 1'b0;
    w_zeroExt  = 1'b0;
    w_isBeq    = 1'b0;
    w_isBne    = 1'b0;
    w_isBgez   = 1'b0;
    w_aluOp    = ALU_ADD;
    casez ({w_op, w_funct})
      {C_SPEC, F_ADDU}:  begin w_regWrite = 1'b1; w_aluOp = ALU_ADD;  end
      {C_SPEC, F_SUBU}:  begin w_regWrite = 1'b1; w_aluOp = ALU_SUB;  end
      {C_SPEC, F_OR}:    begin w_regWrite = 1'b1; w_aluOp = ALU_OR;   end
      {C_SPEC, F_SLTU}:  begin w_regWrite = 1'b1; w_aluOp = ALU_SLTU; end
      {C_SPEC, F_SRL}:   begin w_regWrite = 1'b1; w_aluOp = ALU_SRL;  end
      {C_SPEC, F_SRLV}:  begin w_regWrite = 1'b1; w_aluOp = ALU_SRLV; end
      {C_SPEC2, F_MUL}:  begin w_regWrite = 1'b1; w_aluOp = ALU_MUL;  end
      {C_ADDIU, F_ANY}: begin
        w_regWrite = 1'b1; w_dstRt = 1'b1; w_useImm = 1'b1; w_aluOp = ALU_ADD;
      end
      {C_ANDI, F_ANY}: begin
        w_regWrite = 1'b1; w_dstRt = 1'b1; w_useImm = 1'b1; w_zeroExt = 1'b1;
        w_aluOp    = ALU_AND;
      end
      {C_LUI, F_ANY}: begin
        w_regWrite = 1'b1; w_dstRt = 1'b1; w_aluOp = ALU_LUI;
      end
      {C_BEQ, F_ANY}:  w_isBeq  = 1'b1;
      {C_BNE, F_ANY}:  w_isBne  = 1'b1;
      // REGIMM group: only rt=00001 (BGEZ) is implemented
      {C_BGEZ, F_ANY}: w_isBgez = (w_rt == 5'd1);
      default: ;
    endcase
  end

  // ------------------------------------------------------------------ ALU
  assign w_srcB = !w_useImm ? w_rtData :
                  w_zeroExt ? {16'd0, w_imm} : signExt16(w_imm);

  always_comb begin
    w_aluResult = 32'd0;
    case (w_aluOp)
      ALU_ADD:  w_aluResult = w_rsData + w_srcB;
      ALU_SUB:  w_aluResult = w_rsData - w_srcB;
      ALU_OR:   w_aluResult = w_rsData | w_srcB;
      ALU_AND:  w_aluResult = w_rsData & w_srcB;
      ALU_SLTU: w_aluResult = {31'd0, (w_rsData < w_srcB)};
      ALU_SRL:  w_aluResult = w_srcB >> w_sa;
      ALU_SRLV: w_aluResult = w_srcB >> w_rsData[4:0];
      ALU_MUL:  w_aluResult = w_rsData * w_srcB;
      ALU_LUI:  w_aluResult = {w_imm, 16'd0};
      default:  w_aluResult = 32'd0;
    endcase
  end

  // ------------------------------------------------------ register file
  assign w_wrAddr = w_dstRt ? w_rt : w_rd;
  assign w_wrEn   = w_regWrite && !rst;

  sm_register_file rf (
    .clk       (clk),
    .rdAddr0   (w_rs),
    .rdAddr1   (w_rt),
    .rdAddrDbg (bus.regAddr),
    .rdData0   (w_rsData),
    .rdData1   (w_rtData),
    .rdDataDbg (w_dbgData),
    .wrAddr    (w_wrAddr),
    .wrData    (w_aluResult),
    .wrEn      (w_wrEn)
  );

  // ------------------------------------------------------------ next PC
  assign w_taken  = (w_isBeq  && (w_rsData == w_rtData)) ||
                    (w_isBne  && (w_rsData != w_rtData)) ||
                    (w_isBgez && !w_rsData[31]);
  // Branch target is relative to the following word; wraps modulo 2^32.
  assign w_pcNext = r_pc + 32'd1 + (w_taken ? signExt16(w_imm) : 32'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_pcNext;
    end
  end

  // ------------------------------------------------------------- debug
  assign bus.regData = (bus.regAddr == 5'd0) ? r_pc : w_dbgData;

endmodule
`default_nettype wire

// File: tb/tb_school_mips_cpu.sv
`default_nettype none
// ============================================================================
// Module   : tb_school_mips_cpu
// Purpose  : Self-checking bench for school_mips_cpu. Holds the 64-word
//            program ROM, an instruction-level reference model and a small
//            disassembler used to label comparisons.
// Revision : 1.0  initial release
// ============================================================================
module tb_school_mips_cpu;
  import school_mips_cpu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  school_mips_cpu_if bus ();

  school_mips_cpu #(.RESET_PC(32'd0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // 64-word ROM, aliases modulo 64
  logic [31:0] rom [64];
  assign bus.imData = rom[bus.imAddr[5:0]];

  // reference machine state
  logic [31:0] m_gpr [32];
  logic [31:0] m_pc;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // ------------------------------------------------------------ encoders
  function automatic logic [31:0] rtype(input logic [5:0] op, input logic [5:0] fn,
                                        input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sa);
    return {op, rs, rt, rd, sa, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic string disasm(input logic [31:0] ins);
    logic [5:0] op;
    logic [5:0] fn;
    op = ins[31:26];
    fn = ins[5:0];
    if (op == C_SPEC && fn == F_ADDU) return "addu";
    if (op == C_SPEC && fn == F_SUBU) return "subu";
    if (op == C_SPEC && fn == F_OR)   return "or";
    if (op == C_SPEC && fn == F_SLTU) return "sltu";
    if (op == C_SPEC && fn == F_SRL)  return "srl";
    if (op == C_SPEC && fn == F_SRLV) return "srlv";
    if (op == C_SPEC2 && fn == F_MUL) return "mul";
    if (op == C_ADDIU) return "addiu";
    if (op == C_ANDI)  return "andi";
    if (op == C_LUI)   return "lui";
    if (op == C_BEQ)   return "beq";
    if (op == C_BNE)   return "bne";
    if (op == C_BGEZ && ins[20:16] == 5'd1) return "bgez";
    return "nop/unknown";
  endfunction

  // ------------------------------------------------------ reference model
  // Executes one instruction on the architectural state; returns the GPR
  // written (or -1 when nothing visible was written).
  task automatic modelStep(output int dst);
    logic [31:0] ins, a, b, sImm, val;
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, sa;
    logic [15:0] imm;
    bit          taken;
    ins = rom[m_pc[5:0]];
    op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
    sa = ins[10:6];  fn = ins[5:0];   imm = ins[15:0];
    a = m_gpr[rs]; b = m_gpr[rt];
    sImm = {{16{imm[15]}}, imm};
    dst = -1; val = 0; taken = 0;
    if (op == C_SPEC) begin
      if (fn == F_ADDU)      begin dst = rd; val = a + b; end
      else if (fn == F_SUBU) begin dst = rd; val = a - b; end
      else if (fn == F_OR)   begin dst = rd; val = a | b; end
      else if (fn == F_SLTU) begin dst = rd; val = (a < b) ? 32'd1 : 32'd0; end
      else if (fn == F_SRL)  begin dst = rd; val = b >> sa; end
      else if (fn == F_SRLV) begin dst = rd; val = b >> a[4:0]; end
    end else if (op == C_SPEC2 && fn == F_MUL) begin
      dst = rd; val = a * b;
    end else if (op == C_ADDIU) begin dst = rt; val = a + sImm;
    end else if (op == C_ANDI)  begin dst = rt; val = a & {16'd0, imm};
    end else if (op == C_LUI)   begin dst = rt; val = {imm, 16'd0};
    end else if (op == C_BEQ)   taken = (a == b);
    else if (op == C_BNE)       taken = (a != b);
    else if (op == C_BGEZ && rt == 5'd1) taken = ($signed(a) >= 0);
    if (dst > 0) m_gpr[dst] = val;
    else dst = -1;
    m_pc = taken ? m_pc + 32'd1 + sImm : m_pc + 32'd1;
  endtask

  // ------------------------------------------------------------- helpers
  task automatic readReg(input int a, output logic [31:0] v);
    bus.regAddr = 5'(a);
    #1;
    v = bus.regData;
  endtask

  // Called with rst already asserted so the core cannot write meanwhile.
  task automatic clearRom();
    for (int i = 0; i < 64; i++) rom[i] = 32'd0;
  endtask

  task automatic initRegs();
    logic [31:0] v;
    m_gpr[0] = 32'd0;
    for (int k = 1; k < 32; k++) begin
      v = $urandom();
      dut.rf.rf[k] = v;
      m_gpr[k] = v;
    end
  endtask

  task automatic doReset();
    logic [31:0] v;
    rst = 1'b1;
    m_pc = 32'd0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #2;
      readReg(0, v);
      check($sformatf("reset pc cycle %0d", i), v, 32'd0);
    end
    rst = 1'b0;
  endtask

  // Step both DUT and model n times; compare PC, destination and one
  // random register each step.
  task automatic runProg(input int n, input bit extra);
    logic [31:0] v;
    int dst, r;
    string d;
    for (int i = 0; i < n; i++) begin
      d = disasm(rom[m_pc[5:0]]);
      modelStep(dst);
      @(posedge clk);
      #2;
      readReg(0, v);
      check({"pc after ", d}, v, m_pc);
      if (dst > 0) begin
        readReg(dst, v);
        check($sformatf("$%0d after %s", dst, d), v, m_gpr[dst]);
      end
      if (extra) begin
        r = $urandom_range(1, 31);
        readReg(r, v);
        check($sformatf("$%0d spot", r), v, m_gpr[r]);
      end
    end
  endtask

  function automatic logic [31:0] randInstr();
    logic [4:0]  rs, rt, rd, sa;
    logic [15:0] imm, off;
    rs  = 5'($urandom_range(0, 7));
    rt  = 5'($urandom_range(0, 7));
    rd  = 5'($urandom_range(0, 7));
    sa  = 5'($urandom_range(0, 31));
    imm = 16'($urandom());
    off = 16'($urandom_range(0, 6)) - 16'd3;
    case ($urandom_range(0, 15))
      0:  return rtype(C_SPEC, F_ADDU, rs, rt, rd, 5'd0);
      1:  return rtype(C_SPEC, F_SUBU, rs, rt, rd, 5'd0);
      2:  return rtype(C_SPEC, F_OR, rs, rt, rd, 5'd0);
      3:  return rtype(C_SPEC, F_SLTU, rs, rt, rd, 5'd0);
      4:  return rtype(C_SPEC, F_SRL, 5'd0, rt, rd, sa);
      5:  return rtype(C_SPEC, F_SRLV, rs, rt, rd, 5'd0);
      6:  return rtype(C_SPEC2, F_MUL, rs, rt, rd, 5'd0);
      7:  return itype(C_ADDIU, rs, rt, imm);
      8:  return itype(C_ANDI, rs, rt, imm);
      9:  return itype(C_LUI, 5'd0, rt, imm);
      10: return itype(C_BEQ, rs, rt, off);
      11: return itype(C_BNE, rs, rt, off);
      12: return itype(C_BGEZ, rs, 5'd1, off);
      13: return $urandom();
      14: return 32'd0;
      default: return itype(C_BGEZ, rs, rt, off);
    endcase
  endfunction

  // ---------------------------------------------------------------- main
  initial begin
    logic [31:0] v;
    bus.regAddr = 5'd0;

    // reset then NOPs: PC 1, 2, 3
    rst = 1'b1;
    clearRom();
    initRegs();
    doReset();
    for (int i = 1; i <= 3; i++) begin
      runProg(1, 1'b0);
      readReg(0, v);
      check($sformatf("nop pc %0d", i), v, 32'(i));
    end

    // arithmetic and sltu
    rst = 1'b1;
    clearRom();
    rom[0] = itype(C_ADDIU, 5'd0, 5'd2, 16'd5);
    rom[1] = itype(C_ADDIU, 5'd0, 5'd3, 16'd3);
    rom[2] = rtype(C_SPEC, F_ADDU, 5'd2, 5'd3, 5'd2, 5'd0);
    rom[3] = rtype(C_SPEC, F_SUBU, 5'd2, 5'd3, 5'd4, 5'd0);
    rom[4] = rtype(C_SPEC, F_SLTU, 5'd3, 5'd2, 5'd5, 5'd0);
    rom[5] = rtype(C_SPEC, F_SLTU, 5'd2, 5'd3, 5'd6, 5'd0);
    initRegs();
    doReset();
    runProg(6, 1'b0);
    readReg(2, v); check("addu $2", v, 32'd8);
    readReg(4, v); check("subu $4", v, 32'd5);
    readReg(5, v); check("sltu $5", v, 32'd1);
    readReg(6, v); check("sltu swapped $6", v, 32'd0);

    // lui / andi / srl / srlv
    rst = 1'b1;
    clearRom();
    rom[0] = itype(C_LUI, 5'd0, 5'd2, 16'h1234);
    rom[1] = itype(C_ANDI, 5'd2, 5'd3, 16'hFFFF);
    rom[2] = rtype(C_SPEC, F_SRL, 5'd0, 5'd2, 5'd4, 5'd16);
    rom[3] = itype(C_ADDIU, 5'd0, 5'd6, 16'd4);
    rom[4] = rtype(C_SPEC, F_SRLV, 5'd6, 5'd2, 5'd7, 5'd0);
    initRegs();
    doReset();
    runProg(5, 1'b0);
    readReg(2, v); check("lui $2", v, 32'h1234_0000);
    readReg(3, v); check("andi $3", v, 32'h0000_0000);
    readReg(4, v); check("srl $4", v, 32'h0000_1234);
    readReg(7, v); check("srlv $7", v, 32'h0123_4000);

    // mul, low word of product
    rst = 1'b1;
    clearRom();
    rom[0] = itype(C_LUI, 5'd0, 5'd3, 16'h0001);
    rom[1] = itype(C_LUI, 5'd0, 5'd4, 16'h0001);
    rom[2] = itype(C_ADDIU, 5'd4, 5'd4, 16'd3);
    rom[3] = rtype(C_SPEC2, F_MUL, 5'd3, 5'd4, 5'd2, 5'd0);
    initRegs();
    doReset();
    runProg(4, 1'b0);
    readReg(2, v); check("mul $2", v, 32'h0003_0000);

    // beq $0,$0,-1 at PC 5 spins
    rst = 1'b1;
    clearRom();
    rom[5] = itype(C_BEQ, 5'd0, 5'd0, 16'hFFFF);
    initRegs();
    doReset();
    runProg(9, 1'b0);
    readReg(0, v); check("beq spin pc", v, 32'd5);

    // bne fall-through, bgez not taken / taken
    rst = 1'b1;
    clearRom();
    rom[0] = itype(C_ADDIU, 5'd0, 5'd2, 16'hFFFF);
    rom[1] = itype(C_BNE, 5'd2, 5'd2, 16'd10);
    rom[2] = itype(C_BGEZ, 5'd2, 5'd1, 16'd5);
    rom[3] = itype(C_ADDIU, 5'd0, 5'd2, 16'd0);
    rom[4] = itype(C_BGEZ, 5'd2, 5'd1, 16'd3);
    initRegs();
    doReset();
    begin
      logic [31:0] expPc [5] = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd8};
      for (int i = 0; i < 5; i++) begin
        runProg(1, 1'b0);
        readReg(0, v);
        check($sformatf("branch seq pc %0d", i), v, expPc[i]);
      end
    end

    // writes to $0 are dropped; $0 reads as zero
    rst = 1'b1;
    clearRom();
    rom[0] = itype(C_ADDIU, 5'd0, 5'd0, 16'd7);
    rom[1] = rtype(C_SPEC, F_ADDU, 5'd0, 5'd0, 5'd2, 5'd0);
    initRegs();
    dut.rf.rf[2] = 32'hDEAD_BEEF;
    m_gpr[2] = 32'hDEAD_BEEF;
    doReset();
    runProg(1, 1'b0);
    readReg(0, v); check("sel0 after write $0", v, 32'd1);
    runProg(1, 1'b0);
    readReg(2, v); check("addu $2,$0,$0", v, 32'd0);

    // randomized programs against the model
    for (int round = 0; round < 6; round++) begin
      rst = 1'b1;
      for (int i = 0; i < 64; i++) rom[i] = randInstr();
      initRegs();
      doReset();
      runProg(120, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/school_mips_cpu.md
Name: school_mips_cpu

Overview:
- Single-cycle MIPS-subset CPU core, same role as the team's sm_cpu.
- Fetches from an external combinational instruction ROM (sm_rom) using a word-indexed PC.
- Executes one instruction per clock with no pipeline and no branch delay slot.
- Provides a debug read port that returns the PC or any GPR.

Parameters:
- RESET_PC, 0, word address loaded into the PC on reset.

Ports:
- clk      in   1   clock; all state updates on the rising edge
- rst      in   1   reset, synchronous, active-high
- regAddr  in   5   debug select: 0 returns PC, 1..31 return GPR[regAddr]
- regData  out  32  debug read data, combinational
- imAddr   out  32  instruction word address (= PC)
- imData   in   32  instruction word from ROM, combinational

Behaviour:
- Clocking and reset:
  - One clock. Reset is synchronous and active-high.
  - While rst=1 at a rising edge, PC <= RESET_PC. While reset is held, no GPR writes occur.
  - GPRs are not reset; the bench initialises them.
- Fetch:
  - imAddr = PC, as a word address. Byte address = PC<<2.
  - Internal signal instr = imData.
- PC update, every non-reset edge:
  - Branch taken: PC <= PC + 1 + signext(imm16).
  - Otherwise: PC <= PC + 1.
  - The PC wraps modulo 2^32.
- Register file:
  - 32x32, two asynchronous read ports, one write port written on the rising edge.
  - Reads of $0 return 0. Writes to $0 are discarded.
  - Instance name is rf, with the storage array also named rf, so the bench can initialise it as rf.rf[k].
- Debug port: regData = (regAddr==0) ? PC : GPR[regAddr].
- Instruction decode (op[31:26], rs[25:21], rt[20:16], rd[15:11], sa[10:6], funct[5:0]):
  - SPECIAL op=000000, destination rd:
    - ADDU funct=100001: rs+rt
    - SUBU funct=100011: rs-rt
    - OR funct=100101: rs|rt
    - SLTU funct=101011: (rs<rt unsigned) ? 1 : 0
    - SRL funct=000010: rt>>sa, logical
    - SRLV funct=000110: rt>>rs[4:0], logical
  - SPECIAL2 op=011100, MUL funct=000010: rd <= low 32 bits of rs*rt.
  - ADDIU op=001001: rt <= rs+signext(imm).
  - ANDI op=001100: rt <= rs&zeroext(imm).
  - LUI op=001111: rt <= {imm,16'b0}.
  - BEQ op=000100: taken if rs==rt.
  - BNE op=000101: taken if rs!=rt.
  - BGEZ op=000001 with rt=00001: taken if rs[31]==0.
  - All add/sub arithmetic is 32-bit wraparound; no overflow traps.
- Unknown encodings, including 0x00000000 (NOP = sll $0,$0,0), perform no register write and PC <= PC+1.
- Writeback and forwarding:
  - Writeback occurs on the same edge that advances the PC.
  - A read of a register written by the previous instruction sees the new value; no hazards exist.
- Companion ROM (sm_rom):
  - 64 words, asynchronous read indexed by a[5:0].
  - Contents loaded at elaboration from program.hex.
  - Out-of-range addresses alias modulo 64.

Decomposition:
- Shared package holds:
  - opcode constants: C_SPEC, C_SPEC2, C_ADDIU, C_LUI, C_ANDI, C_BEQ, C_BNE, C_BGEZ
  - funct constants: F_ADDU, F_OR, F_SRL, F_SLTU, F_SUBU, F_SRLV, F_MUL, F_ANY (wildcard)
  - ALU operation encoding
- The testbench disassembler uses the same package.
- Sub-modules:
  - sm_register_file (instance rf), natural and required for hierarchical access.
  - Control decoder and ALU are combinational blocks inside the core.

Test Plan:
- Reset: hold rst=1 for 4 cycles, then release. Required: regData(regAddr=0)=0 during reset, then 1, 2, 3 on successive cycles when executing NOPs.
- Program "addiu $2,$0,5; addiu $3,$0,3; addu $2,$2,$3; subu $4,$2,$3". Required after execution: $2=8, $4=5. Also "sltu $5,$3,$2" gives $5=1; swapping operands gives 0.
- Program "lui $2,0x1234; andi $3,$2,0xFFFF; srl $4,$2,16; addiu $6,$0,4; srlv $7,$2,$6". Required: $2=0x12340000, $3=0, $4=0x1234, $7=0x01234000.
- SPECIAL2 "mul $2,$3,$4" with $3=0x10000 and $4=0x10003. Required: $2=0x30000, the low word of the product.
- Branches:
  - "beq $0,$0,-1" at PC 5 leaves the PC stuck at 5.
  - "bne $2,$2,x" falls through to PC+1.
  - bgez on $2=0xFFFFFFFF is not taken; bgez on $2=0 jumps to PC+1+imm.
- Writes to $0 ("addiu $0,$0,7") leave regData for $0-select at the PC value. GPR $0 reads as 0 in a following "addu $2,$0,$0".
